// File: rtl/lsu_region_decoder_pkg.sv
// Shared definitions for the load/store region decoder:
// funct3 size codes, the load FSM state type and the default region map.
package lsu_pkg;

    // funct3 encodings for RV32I loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Load sequencing: IDLE issues, RESP returns the synchronous read
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } lsu_state_e;

    // Default memory map: data RAM, output IO block, switch input block
    localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_MASK = 32'hFFFF_F800;
    localparam logic [31:0] IO_BASE   = 32'h1000_0000;
    localparam logic [31:0] IO_MASK   = 32'hFFFF_0000;
    localparam logic [31:0] SW_BASE   = 32'h1001_0000;
    localparam logic [31:0] SW_MASK   = 32'hFFFF_F000;

    // Region 0 is the rightmost entry of the packed arrays
    localparam logic [95:0] DEFAULT_BASE = {SW_BASE, IO_BASE, DMEM_BASE};
    localparam logic [95:0] DEFAULT_MASK = {SW_MASK, IO_MASK, DMEM_MASK};

    // A funct3 code is legal for loads if it is one of the five load sizes,
    // and legal for stores only for the three unsigned-agnostic sizes.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_region_decoder_if.sv
// Load/store bus between the RV32I datapath and the region decoder.
// The datapath side (and the region read data) is the master; the decoder is
// the slave. Optional fault-capture outputs exist only when
// LSU_FAULT_CAPTURE_EN is defined.
interface lsu_region_decoder_if #(
    parameter int NUM_REGIONS = 3,
    parameter int ADDR_W      = 32
);
    logic [ADDR_W-1:0]         i_addr;
    logic [31:0]               i_wdata;
    logic [2:0]                i_funct3;
    logic                      i_load;
    logic                      i_store;
    logic [NUM_REGIONS-1:0]    o_sel;
    logic [NUM_REGIONS-1:0]    o_wren;
    logic [3:0]                o_bmask;
    logic [31:0]               o_wdata;
    logic [32*NUM_REGIONS-1:0] i_rdata;
    logic [31:0]               o_ld_data;
    logic                      o_ld_valid;
    logic                      o_stall;
    logic                      o_fault;
`ifdef LSU_FAULT_CAPTURE_EN
    logic [ADDR_W-1:0]         o_fault_addr;
    logic [7:0]                o_fault_cnt;

    modport master (
        output i_addr, i_wdata, i_funct3, i_load, i_store, i_rdata,
        input  o_sel, o_wren, o_bmask, o_wdata, o_ld_data, o_ld_valid,
               o_stall, o_fault, o_fault_addr, o_fault_cnt
    );

    modport slave (
        input  i_addr, i_wdata, i_funct3, i_load, i_store, i_rdata,
        output o_sel, o_wren, o_bmask, o_wdata, o_ld_data, o_ld_valid,
               o_stall, o_fault, o_fault_addr, o_fault_cnt
    );
`else
    modport master (
        output i_addr, i_wdata, i_funct3, i_load, i_store, i_rdata,
        input  o_sel, o_wren, o_bmask, o_wdata, o_ld_data, o_ld_valid,
               o_stall, o_fault
    );

    modport slave (
        input  i_addr, i_wdata, i_funct3, i_load, i_store, i_rdata,
        output o_sel, o_wren, o_bmask, o_wdata, o_ld_data, o_ld_valid,
               o_stall, o_fault
    );
`endif
endinterface

// File: rtl/lsu_region_decoder_load_align.sv
// Load data alignment: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to funct3. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_word >> {i_offset, 3'b000};

    // Extend the low byte/half of the shifted word per the load type
    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_data = {24'h0, w_shifted[7:0]};
            F3_HU:   o_data = {16'h0, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_region_decoder.sv
// Load/store region decoder and data steering unit.
// Decodes the effective address against NUM_REGIONS base/mask pairs
// (lowest index wins), drives per-region select/write-enable, byte mask and
// lane-replicated store data, and sequences a one-cycle wait for loads
// because regions read synchronously. Illegal, misaligned or unmapped
// accesses raise o_fault instead of touching any region.
// Optional feature macro: LSU_FAULT_CAPTURE_EN adds o_fault_addr/o_fault_cnt.
module lsu_region_decoder
    import lsu_pkg::*;
#(
    parameter int                            NUM_REGIONS = 3,
    parameter int                            ADDR_W      = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_MASK
)(
    input  logic                  i_clk,
    input  logic                  i_reset,
    lsu_region_decoder_if.slave   bus
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    lsu_state_e              r_state;
    logic                    r_ld_valid;
    logic [IDX_W-1:0]        r_idx;
    logic [2:0]              r_funct3;
    logic [1:0]              r_offset;
    logic [31:0]             r_ld_hold;

    logic [NUM_REGIONS-1:0]  w_hit;
    logic                    w_mapped;
    logic [IDX_W-1:0]        w_idx;
    logic [NUM_REGIONS-1:0]  w_onehot;
    logic                    w_req;
    logic                    w_f3_ok;
    logic [1:0]              w_size;
    logic                    w_misal;
    logic                    w_legal;
    logic                    w_idle;
    logic                    w_go;
    logic                    w_fault;
    logic [3:0]              w_bmask;
    logic [31:0]             w_wdata;
    logic [31:0]             w_word;
    logic [31:0]             w_aligned;

    genvar g;
    generate
        for (g = 0; g < NUM_REGIONS; g++) begin : g_match
            assign w_hit[g] = ((bus.i_addr & REGION_MASK[g*ADDR_W +: ADDR_W])
                               == REGION_BASE[g*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Priority encoder: scan from the top so the lowest hitting index wins
    always_comb begin
        w_mapped = 1'b0;
        w_idx    = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_mapped = 1'b1;
                w_idx    = k[IDX_W-1:0];
            end
        end
    end

    assign w_onehot = NUM_REGIONS'(1) << w_idx;

    // funct3[1:0] is 00 byte, 01 half, 10 word for every legal code
    assign w_req   = bus.i_load | bus.i_store;
    assign w_f3_ok = f3_legal(bus.i_funct3, bus.i_load);
    assign w_size  = bus.i_funct3[1:0];
    assign w_misal = ((w_size == 2'b01) && bus.i_addr[0]) ||
                     ((w_size == 2'b10) && (bus.i_addr[1:0] != 2'b00));

    // Load and store together is treated like any other illegal request
    assign w_legal = w_req && !(bus.i_load && bus.i_store) && w_f3_ok &&
                     !w_misal && w_mapped;

    // In RESP the inputs still carry the held load; they are not a new access
    assign w_idle  = (r_state == IDLE);
    assign w_go    = w_idle && w_legal;
    assign w_fault = w_idle && w_req && !w_legal;

    // Byte lanes touched by the current legal access
    always_comb begin
        w_bmask = 4'b0000;
        if (w_go) begin
            case (w_size)
                2'b00:   w_bmask = 4'b0001 << bus.i_addr[1:0];
                2'b01:   w_bmask = 4'b0011 << bus.i_addr[1:0];
                default: w_bmask = 4'b1111;
            endcase
        end
    end

    // Replicate narrow store data across all lanes; the byte mask picks one
    always_comb begin
        case (w_size)
            2'b00:   w_wdata = {4{bus.i_wdata[7:0]}};
            2'b01:   w_wdata = {2{bus.i_wdata[15:0]}};
            default: w_wdata = bus.i_wdata;
        endcase
    end

    // Pick the read-data slice of the region captured at load issue
    always_comb begin
        w_word = bus.i_rdata[31:0];
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (r_idx == k[IDX_W-1:0]) begin
                w_word = bus.i_rdata[k*32 +: 32];
            end
        end
    end

    lsu_load_align u_load_align (
        .i_word   (w_word),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_aligned)
    );

    // Load FSM: capture the access in IDLE, deliver the result in RESP
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_ld_valid <= 1'b0;
            r_idx      <= '0;
            r_funct3   <= 3'b000;
            r_offset   <= 2'b00;
            r_ld_hold  <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go && bus.i_load) begin
                        r_idx      <= w_idx;
                        r_funct3   <= bus.i_funct3;
                        r_offset   <= bus.i_addr[1:0];
                        r_ld_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    r_ld_hold  <= w_aligned;
                    r_ld_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_ld_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_sel      = w_go ? w_onehot : '0;
    assign bus.o_wren     = (w_go && bus.i_store) ? w_onehot : '0;
    assign bus.o_stall    = w_go && bus.i_load;
    assign bus.o_fault    = w_fault;
    assign bus.o_bmask    = w_bmask;
    assign bus.o_wdata    = w_wdata;
    assign bus.o_ld_valid = r_ld_valid;
    assign bus.o_ld_data  = r_ld_valid ? w_aligned : r_ld_hold;

`ifdef LSU_FAULT_CAPTURE_EN
    logic [ADDR_W-1:0] r_fault_addr;
    logic [7:0]        r_fault_cnt;

    // Record the last faulting address and a saturating fault count
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fault_addr <= '0;
            r_fault_cnt  <= 8'h00;
        end else if (w_fault) begin
            r_fault_addr <= bus.i_addr;
            if (r_fault_cnt != 8'hFF) begin
                r_fault_cnt <= r_fault_cnt + 8'h01;
            end
        end
    end

    assign bus.o_fault_addr = r_fault_addr;
    assign bus.o_fault_cnt  = r_fault_cnt;
`endif

endmodule

// File: tb/tb_lsu_region_decoder.sv
// Bench for lsu_region_decoder: directed vectors with literal expectations,
// plus a memory-map model compared against the DUT on every cycle.
module tb_lsu_region_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lsu_region_decoder_if #(.NUM_REGIONS(3), .ADDR_W(32)) bus ();

    lsu_region_decoder dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory map as the model sees it
    logic [31:0] m_base [3] = '{32'h0000_0000, 32'h1000_0000, 32'h1001_0000};
    logic [31:0] m_mask [3] = '{32'hFFFF_F800, 32'hFFFF_0000, 32'hFFFF_F000};

    bit          m_init  = 0;
    bit          m_resp  = 0;
    int          m_reg   = 0;
    int          m_off   = 0;
    logic [2:0]  m_f3    = 3'b000;
    logic [31:0] m_hold  = 32'h0;
    int          m_fcnt  = 0;
    logic [31:0] m_faddr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        for (int k = 0; k < 3; k++)
            if ((a & m_mask[k]) == m_base[k]) return k;
        return -1;
    endfunction

    // Access size in bytes, 0 when the code is not a legal access of that kind
    function automatic int size_of(input logic [2:0] f3, input bit is_load);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b100:  return is_load ? 1 : 0;
            3'b101:  return is_load ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [2:0] f3,
                                 input bit ld, input bit st);
        int sz;
        if (ld == st) return 0;
        sz = size_of(f3, ld);
        if (sz == 0) return 0;
        if ((a % sz) != 0) return 0;
        return region_of(a) >= 0;
    endfunction

    function automatic logic [31:0] ld_value(input logic [31:0] word, input int off,
                                             input logic [2:0] f3);
        longint v;
        longint lim;
        int sz;
        sz  = size_of(f3, 1);
        v   = longint'(word >> (8 * off));
        lim = longint'(1) << (8 * sz);
        v   = v % lim;
        if (!f3[2] && sz < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    // Model state advances on the same edge as the DUT
    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1;
            m_resp  = 0;
            m_hold  = 32'h0;
            m_fcnt  = 0;
            m_faddr = 32'h0;
        end else if (m_resp) begin
            m_hold = ld_value(bus.i_rdata[m_reg*32 +: 32], m_off, m_f3);
            m_resp = 0;
        end else if (legal(bus.i_addr, bus.i_funct3, bus.i_load, bus.i_store)) begin
            if (bus.i_load) begin
                m_resp = 1;
                m_reg  = region_of(bus.i_addr);
                m_off  = int'(bus.i_addr % 4);
                m_f3   = bus.i_funct3;
            end
        end else if (bus.i_load || bus.i_store) begin
            m_faddr = bus.i_addr;
            if (m_fcnt < 255) m_fcnt++;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_init) begin
            int          r;
            int          sz;
            int          bm;
            bit          lg;
            bit          go;
            bit          req;
            logic [31:0] exp_wd;
            r   = region_of(bus.i_addr);
            lg  = legal(bus.i_addr, bus.i_funct3, bus.i_load, bus.i_store);
            req = bus.i_load || bus.i_store;
            go  = !m_resp && lg;
            sz  = size_of(bus.i_funct3, bus.i_load);
            bm  = go ? (((1 << sz) - 1) << (bus.i_addr % 4)) : 0;
            chk("m_sel",   32'(bus.o_sel),   go ? (32'd1 << r) : 32'd0);
            chk("m_wren",  32'(bus.o_wren),  (go && bus.i_store) ? (32'd1 << r) : 32'd0);
            chk("m_stall", 32'(bus.o_stall), 32'(go && bus.i_load));
            chk("m_fault", 32'(bus.o_fault), 32'(!m_resp && req && !lg));
            chk("m_bmask", 32'(bus.o_bmask), 32'(bm[3:0]));
            chk("m_ldv",   32'(bus.o_ld_valid), 32'(m_resp));
            chk("m_ldd",   bus.o_ld_data,
                m_resp ? ld_value(bus.i_rdata[m_reg*32 +: 32], m_off, m_f3) : m_hold);
            if (go && bus.i_store) begin
                if (sz == 1)      exp_wd = {24'h0, bus.i_wdata[7:0]} * 32'h0101_0101;
                else if (sz == 2) exp_wd = {16'h0, bus.i_wdata[15:0]} * 32'h0001_0001;
                else              exp_wd = bus.i_wdata;
                chk("m_wdata", bus.o_wdata, exp_wd);
            end
`ifdef LSU_FAULT_CAPTURE_EN
            chk("m_fcnt",  32'(bus.o_fault_cnt), 32'(m_fcnt));
            chk("m_faddr", bus.o_fault_addr, m_faddr);
`endif
        end
    end

    task automatic drive(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.i_load   = ld;
        bus.i_store  = st;
        bus.i_funct3 = f3;
        bus.i_addr   = a;
        bus.i_wdata  = wd;
    endtask

    task automatic set_rd(input int slot, input logic [31:0] v);
        bus.i_rdata = '0;
        bus.i_rdata[slot*32 +: 32] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        drive(0, 0, 3'b000, 32'h0, 32'h0);
        bus.i_rdata = '0;
    endtask

    // Issue a load, then return rdata in the RESP cycle with the load held
    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input int slot, input logic [31:0] rd,
                           input logic [2:0] sel_exp, input logic [31:0] data_exp);
        drive(1, 0, f3, a, 32'h0);
        set_rd(slot, 32'h0);
        @(negedge clk);
        chk({nm, "_stall"}, 32'(bus.o_stall), 32'd1);
        chk({nm, "_sel"},   32'(bus.o_sel),   32'(sel_exp));
        tick();
        set_rd(slot, rd);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.o_ld_valid), 32'd1);
        chk({nm, "_data"},  bus.o_ld_data, data_exp);
        chk({nm, "_rsel"},  32'(bus.o_sel), 32'd0);
        tick();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ldv",   32'(bus.o_ld_valid), 32'd0);
        chk("rst_ldd",   bus.o_ld_data, 32'h0);
        chk("rst_stall", 32'(bus.o_stall), 32'd0);
        chk("rst_sel",   32'(bus.o_sel), 32'd0);
        rst = 1'b0;
        tick();

        drive(0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_wren",  32'(bus.o_wren), 32'b001);
        chk("sw_bmask", 32'(bus.o_bmask), 32'hF);
        chk("sw_wdata", bus.o_wdata, 32'hDEAD_BEEF);
        chk("sw_stall", 32'(bus.o_stall), 32'd0);
        tick();

        drive(0, 1, 3'b000, 32'h1000_0003, 32'h0000_00A5);
        @(negedge clk);
        chk("sb_wren",  32'(bus.o_wren), 32'b010);
        chk("sb_bmask", 32'(bus.o_bmask), 32'b1000);
        chk("sb_wdata", bus.o_wdata, 32'hA5A5_A5A5);
        tick();

        do_load("lb",  3'b000, 32'h0000_0002, 0, 32'h0080_0000, 3'b001, 32'hFFFF_FF80);
        idle_in();
        @(negedge clk);
        chk("lb_hold", bus.o_ld_data, 32'hFFFF_FF80);
        chk("lb_idlev", 32'(bus.o_ld_valid), 32'd0);
        tick();
        do_load("lbu", 3'b100, 32'h0000_0002, 0, 32'h0080_0000, 3'b001, 32'h0000_0080);
        do_load("lw",  3'b010, 32'h1001_0000, 2, 32'h0000_03FF, 3'b100, 32'h0000_03FF);
        // back-to-back halfword loads from the IO region
        do_load("lhu", 3'b101, 32'h1000_0002, 1, 32'h8001_0000, 3'b010, 32'h0000_8001);
        do_load("lh",  3'b001, 32'h1000_0002, 1, 32'h8001_0000, 3'b010, 32'hFFFF_8001);
        idle_in();
        tick();

        drive(1, 0, 3'b001, 32'h0000_0001, 32'h0);
        @(negedge clk);
        chk("mis_fault", 32'(bus.o_fault), 32'd1);
        chk("mis_wren",  32'(bus.o_wren), 32'd0);
        chk("mis_stall", 32'(bus.o_stall), 32'd0);
        tick();
        drive(0, 1, 3'b010, 32'h0000_0900, 32'h1234_5678);
        @(negedge clk);
        chk("unm_fault", 32'(bus.o_fault), 32'd1);
        chk("unm_wren",  32'(bus.o_wren), 32'd0);
        chk("unm_sel",   32'(bus.o_sel), 32'd0);
        tick();
        idle_in();
        @(negedge clk);
`ifdef LSU_FAULT_CAPTURE_EN
        chk("fc_cnt",  32'(bus.o_fault_cnt), 32'd2);
        chk("fc_addr", bus.o_fault_addr, 32'h0000_0900);
`endif
        tick();

        // further fault kinds: bad funct3, store with load code, load+store
        drive(1, 0, 3'b011, 32'h0000_0000, 32'h0);
        @(negedge clk);
        chk("f3_fault", 32'(bus.o_fault), 32'd1);
        tick();
        drive(0, 1, 3'b100, 32'h0000_0004, 32'h0);
        @(negedge clk);
        chk("sbu_fault", 32'(bus.o_fault), 32'd1);
        tick();
        drive(1, 1, 3'b010, 32'h0000_0004, 32'h0);
        @(negedge clk);
        chk("ldst_fault", 32'(bus.o_fault), 32'd1);
        chk("ldst_stall", 32'(bus.o_stall), 32'd0);
        tick();
        drive(0, 1, 3'b001, 32'h1000_0003, 32'h0);
        @(negedge clk);
        chk("sh_mis_fault", 32'(bus.o_fault), 32'd1);
        tick();

        // store inputs during RESP are the held instruction and are ignored
        drive(1, 0, 3'b010, 32'h0000_0004, 32'h0);
        set_rd(0, 32'h0);
        tick();
        drive(0, 1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D);
        set_rd(0, 32'h0BAD_F00D);
        @(negedge clk);
        chk("resp_wren",  32'(bus.o_wren), 32'd0);
        chk("resp_fault", 32'(bus.o_fault), 32'd0);
        chk("resp_data",  bus.o_ld_data, 32'h0BAD_F00D);
        tick();

        // reset arriving in the RESP cycle drops the load
        drive(1, 0, 3'b010, 32'h1000_0004, 32'h0);
        set_rd(1, 32'h0);
        tick();
        set_rd(1, 32'h5555_AAAA);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_valid_in", 32'(bus.o_ld_valid), 32'd1);
        tick();
        rst = 1'b0;
        idle_in();
        @(negedge clk);
        chk("rr_valid", 32'(bus.o_ld_valid), 32'd0);
        chk("rr_data",  bus.o_ld_data, 32'h0);
        tick();
        drive(0, 1, 3'b010, 32'h0000_0020, 32'h1234_5678);
        @(negedge clk);
        chk("rr_sw_wren",  32'(bus.o_wren), 32'b001);
        chk("rr_sw_wdata", bus.o_wdata, 32'h1234_5678);
        tick();
        idle_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
